// File: rtl/rom_loader_if.sv
// ---------------------------------------------------------------------------
// rom_loader_if
// Purpose : bundles the byte-stream handshake feeding the ROM loader and the
//           ROM write port it drives.
// Signals :
//   byte_i        8   received byte
//   byte_valid_i  1   byte_i valid
//   byte_ready_o  1   loader can accept a byte
//   w_en_o        1   ROM write strobe (one cycle per word)
//   w_addr_o      AW  ROM word address
//   w_data_o      DW  ROM write data
// Handshake: a byte is transferred on a rising clk edge where both
//   byte_valid_i and byte_ready_o are high. The source may hold byte_valid_i
//   high across consecutive cycles to stream one byte per cycle; byte_i must
//   be stable whenever byte_valid_i is high.
// Modports: slave = loader view, master = byte source / ROM observer view.
// ---------------------------------------------------------------------------
interface rom_loader_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          w_en_o;
    logic [AW-1:0] w_addr_o;
    logic [DW-1:0] w_data_o;

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, w_en_o, w_addr_o, w_data_o
    );

    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, w_en_o, w_addr_o, w_data_o
    );
endinterface

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// rom_loader
// Purpose : turns a framed byte stream into 32-bit instruction-ROM writes and
//           holds the core in reset while the image is being loaded.
//           Frame: SYNC_BYTE, LEN_LO, LEN_HI (word count), then LEN words of
//           4 bytes each, LSB first.
// Optional: define ROM_LOADER_CHKSUM_EN to append one checksum byte (XOR of
//           all data bytes) to each frame; a mismatch aborts the frame.
// Ports   :
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   bus          slave modport of rom_loader_if (byte handshake + ROM write)
//   cpu_hold_o   out  hold the core in reset while loading
//   busy_o       out  frame in progress (state != IDLE)
//   done_o       out  one-cycle pulse, image loaded
//   err_o        out  sticky, last frame aborted (cleared by the next SYNC)
//   o_dbg_state  out  current FSM state encoding
// ---------------------------------------------------------------------------
module rom_loader #(
    parameter int         AW        = 12,
    parameter int         DW        = 32,
    parameter int         MEM_NUM   = 4096,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    rom_loader_if.slave bus,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
`ifdef ROM_LOADER_CHKSUM_EN
        S_CHK  = 3'd4,
`endif
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MEM_NUM);

    state_t        r_state;
    logic          r_ready;
    logic          r_hold;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_w_en;
    logic [AW-1:0] r_w_addr;
    logic [DW-1:0] r_w_data;
    logic [AW:0]   r_word_cnt;   // one extra bit so LEN == MEM_NUM fits
    logic [1:0]    r_byte_idx;
    logic [7:0]    r_len_lo;
    logic [15:0]   r_len;
    logic [23:0]   r_word;       // lanes 0..2; lane 3 comes straight from byte_i
`ifdef ROM_LOADER_CHKSUM_EN
    logic [7:0]    r_xor;
`endif

    logic          w_accept;
    logic [15:0]   w_len;
    logic [AW:0]   w_cnt_next;
    logic          w_last;

    assign w_accept   = bus.byte_valid_i && r_ready;
    assign w_len      = {bus.byte_i, r_len_lo};
    assign w_cnt_next = r_word_cnt + (AW+1)'(1);
    assign w_last     = (16'(w_cnt_next) == r_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_hold     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_w_en     <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word     <= '0;
`ifdef ROM_LOADER_CHKSUM_EN
            r_xor      <= '0;
`endif
        end else begin
            r_w_en <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept && bus.byte_i == SYNC_BYTE) begin
                        r_state <= S_LEN0;
                        r_err   <= 1'b0;
                        r_hold  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_LEN0: begin
                    if (w_accept) begin
                        r_len_lo <= bus.byte_i;
                        r_state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (w_len == 16'd0 || w_len > MAX_LEN) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                            r_hold  <= 1'b0;
                            r_ready <= 1'b0;
                        end else begin
                            r_state    <= S_DATA;
                            r_word_cnt <= '0;
                            r_byte_idx <= '0;
`ifdef ROM_LOADER_CHKSUM_EN
                            r_xor      <= '0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
`ifdef ROM_LOADER_CHKSUM_EN
                        r_xor <= r_xor ^ bus.byte_i;
`endif
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= bus.byte_i;
                            2'd1: r_word[15:8]  <= bus.byte_i;
                            2'd2: r_word[23:16] <= bus.byte_i;
                            default: begin
                                // 4th byte: issue the write on the next cycle
                                r_w_en     <= 1'b1;
                                r_w_addr   <= r_word_cnt[AW-1:0];
                                r_w_data   <= {bus.byte_i, r_word};
                                r_word_cnt <= w_cnt_next;
                                if (w_last) begin
`ifdef ROM_LOADER_CHKSUM_EN
                                    r_state <= S_CHK;
`else
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                    r_hold  <= 1'b0;
                                    r_ready <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef ROM_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_hold  <= 1'b0;
                        r_ready <= 1'b0;
                        if (bus.byte_i == r_xor) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_hold  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.byte_ready_o = r_ready;
    assign bus.w_en_o       = r_w_en;
    assign bus.w_addr_o     = r_w_addr;
    assign bus.w_data_o     = r_w_data;
    assign cpu_hold_o       = r_hold;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign err_o            = r_err;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

    logic       clk;
    logic       rst;
    logic       cpu_hold_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [2:0] o_dbg_state;

    int pass_cnt;
    int total_cnt;
    int wr_count;
    logic [11:0] last_addr;
    logic [31:0] last_data;

    rom_loader_if #(.AW(12), .DW(32)) bus ();

    rom_loader dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cpu_hold_o  (cpu_hold_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write observer
    always @(negedge clk) begin
        if (bus.w_en_o === 1'b1) begin
            wr_count  <= wr_count + 1;
            last_addr <= bus.w_addr_o;
            last_data <= bus.w_data_o;
        end
    end

    // driver: present a byte and return #1 after the edge that accepts it
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        while (bus.byte_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            total_cnt++;
            $display("FAIL ready_timeout byte=%h ready=%b required=1", b, bus.byte_ready_o);
        end
        @(posedge clk); #1;
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.byte_i = 8'h00;
        bus.byte_valid_i = 1'b0;
        idle_cycles(3);
        total_cnt++; if (bus.byte_ready_o !== 1'b0) $display("FAIL rst_ready got=%b exp=0", bus.byte_ready_o); else pass_cnt++;
        total_cnt++; if ({cpu_hold_o, busy_o, done_o, err_o, bus.w_en_o} !== 5'b0) $display("FAIL rst_flags got=%b exp=00000", {cpu_hold_o, busy_o, done_o, err_o, bus.w_en_o}); else pass_cnt++;
        total_cnt++; if ({bus.w_addr_o, bus.w_data_o} !== 44'h0) $display("FAIL rst_bus got=%h exp=0", {bus.w_addr_o, bus.w_data_o}); else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (bus.byte_ready_o !== 1'b1) $display("FAIL rst_ready_after got=%b exp=1", bus.byte_ready_o); else pass_cnt++;
    endtask

    task automatic test_garbage();
        logic [7:0] g [3];
        int w0;
        g = '{8'h00, 8'hFF, 8'h3C};
        w0 = wr_count;
        for (int i = 0; i < 3; i++) begin
            send_byte(g[i]);
            total_cnt++; if (busy_o !== 1'b0) $display("FAIL garbage_busy idx=%0d got=%b exp=0", i, busy_o); else pass_cnt++;
        end
        send_byte(8'hA5);
        total_cnt++; if ({busy_o, cpu_hold_o} !== 2'b11) $display("FAIL garbage_sync got=%b exp=11", {busy_o, cpu_hold_o}); else pass_cnt++;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        total_cnt++; if ({bus.w_en_o, bus.w_addr_o, bus.w_data_o} !== {1'b1, 12'h000, 32'h12345678}) $display("FAIL garbage_write got=%b/%h/%h exp=1/000/12345678", bus.w_en_o, bus.w_addr_o, bus.w_data_o); else pass_cnt++;
`ifdef ROM_LOADER_CHKSUM_EN
        send_byte(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12);
`endif
        total_cnt++; if (done_o !== 1'b1) $display("FAIL garbage_done got=%b exp=1", done_o); else pass_cnt++;
        idle_cycles(2);
        total_cnt++; if (wr_count - w0 !== 1) $display("FAIL garbage_wrcount got=%0d exp=1", wr_count - w0); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0] d [8];
        int w0;
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        w0 = wr_count;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(d[i]);
        total_cnt++; if ({bus.w_en_o, bus.w_addr_o, bus.w_data_o} !== {1'b1, 12'h000, 32'h44332211}) $display("FAIL basic_w0 got=%b/%h/%h exp=1/000/44332211", bus.w_en_o, bus.w_addr_o, bus.w_data_o); else pass_cnt++;
        send_byte(d[4]);
        total_cnt++; if (bus.w_en_o !== 1'b0) $display("FAIL basic_wen_pulse got=%b exp=0", bus.w_en_o); else pass_cnt++;
        total_cnt++; if (cpu_hold_o !== 1'b1) $display("FAIL basic_hold got=%b exp=1", cpu_hold_o); else pass_cnt++;
        for (int i = 5; i < 8; i++) send_byte(d[i]);
        total_cnt++; if ({bus.w_en_o, bus.w_addr_o, bus.w_data_o} !== {1'b1, 12'h001, 32'h88776655}) $display("FAIL basic_w1 got=%b/%h/%h exp=1/001/88776655", bus.w_en_o, bus.w_addr_o, bus.w_data_o); else pass_cnt++;
`ifdef ROM_LOADER_CHKSUM_EN
        send_byte(8'h88);
`endif
        total_cnt++; if ({done_o, cpu_hold_o, bus.byte_ready_o, busy_o} !== 4'b1001) $display("FAIL basic_done got=%b exp=1001", {done_o, cpu_hold_o, bus.byte_ready_o, busy_o}); else pass_cnt++;
        idle_cycles(1);
        total_cnt++; if ({done_o, busy_o, bus.byte_ready_o} !== 3'b001) $display("FAIL basic_idle got=%b exp=001", {done_o, busy_o, bus.byte_ready_o}); else pass_cnt++;
        idle_cycles(1);
        total_cnt++; if (wr_count - w0 !== 2) $display("FAIL basic_wrcount got=%0d exp=2", wr_count - w0); else pass_cnt++;
    endtask

    task automatic test_len_errors();
        int w0;
        w0 = wr_count;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        total_cnt++; if ({err_o, cpu_hold_o, done_o} !== 3'b100) $display("FAIL len0_err got=%b exp=100", {err_o, cpu_hold_o, done_o}); else pass_cnt++;
        idle_cycles(2);
        total_cnt++; if (wr_count - w0 !== 0) $display("FAIL len0_nowrite got=%0d exp=0", wr_count - w0); else pass_cnt++;
        total_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err_o); else pass_cnt++;
        send_byte(8'hA5);
        total_cnt++; if (err_o !== 1'b0) $display("FAIL err_clear got=%b exp=0", err_o); else pass_cnt++;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        total_cnt++; if ({bus.w_en_o, bus.w_addr_o, bus.w_data_o} !== {1'b1, 12'h000, 32'hEFBEADDE}) $display("FAIL recover_write got=%b/%h/%h exp=1/000/efbeadde", bus.w_en_o, bus.w_addr_o, bus.w_data_o); else pass_cnt++;
`ifdef ROM_LOADER_CHKSUM_EN
        send_byte(8'h22);
`endif
        total_cnt++; if (done_o !== 1'b1) $display("FAIL recover_done got=%b exp=1", done_o); else pass_cnt++;
        // LEN = 4097 is one past the ROM depth
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        total_cnt++; if ({err_o, o_dbg_state} !== {1'b1, 3'd6}) $display("FAIL len4097_err got=%b/%0d exp=1/6", err_o, o_dbg_state); else pass_cnt++;
        idle_cycles(1);
    endtask

    task automatic test_mid_reset();
        int w0;
        w0 = wr_count;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        rst = 1'b0;
        #2;
        total_cnt++; if ({cpu_hold_o, busy_o, bus.byte_ready_o, err_o, o_dbg_state} !== 7'b0) $display("FAIL midrst_state got=%b exp=0", {cpu_hold_o, busy_o, bus.byte_ready_o, err_o, o_dbg_state}); else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        idle_cycles(5);
        total_cnt++; if (wr_count - w0 !== 1) $display("FAIL midrst_wrcount got=%0d exp=1", wr_count - w0); else pass_cnt++;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h0B);
        total_cnt++; if ({bus.w_en_o, bus.w_addr_o, bus.w_data_o} !== {1'b1, 12'h000, 32'h0BADF00D}) $display("FAIL midrst_reload got=%b/%h/%h exp=1/000/0badf00d", bus.w_en_o, bus.w_addr_o, bus.w_data_o); else pass_cnt++;
`ifdef ROM_LOADER_CHKSUM_EN
        send_byte(8'h5B);
`endif
        total_cnt++; if (done_o !== 1'b1) $display("FAIL midrst_done got=%b exp=1", done_o); else pass_cnt++;
        idle_cycles(1);
    endtask

    task automatic test_full_depth();
        int w0;
        int bad;
        logic [7:0]  b [4];
        logic [7:0]  x;
        logic [31:0] exp_word;
        w0  = wr_count;
        bad = 0;
        x   = 8'h00;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 4096; i++) begin
            b[0] = i[7:0]; b[1] = i[15:8]; b[2] = 8'h5A; b[3] = 8'hC3;
            exp_word = {b[3], b[2], b[1], b[0]};
            for (int k = 0; k < 4; k++) begin
                send_byte(b[k]);
                x = x ^ b[k];
            end
            if (bus.w_en_o !== 1'b1 || bus.w_addr_o !== i[11:0] || bus.w_data_o !== exp_word) begin
                if (bad == 0) $display("FAIL full_word idx=%0d got=%b/%h/%h exp=1/%h/%h", i, bus.w_en_o, bus.w_addr_o, bus.w_data_o, i[11:0], exp_word);
                bad++;
            end
        end
        total_cnt++; if (bad != 0) $display("FAIL full_words bad=%0d exp=0", bad); else pass_cnt++;
        total_cnt++; if (bus.w_addr_o !== 12'hFFF) $display("FAIL full_last_addr got=%h exp=fff", bus.w_addr_o); else pass_cnt++;
`ifdef ROM_LOADER_CHKSUM_EN
        send_byte(x);
`endif
        total_cnt++; if ({done_o, err_o} !== 2'b10) $display("FAIL full_done got=%b exp=10", {done_o, err_o}); else pass_cnt++;
        idle_cycles(2);
        total_cnt++; if (wr_count - w0 !== 4096) $display("FAIL full_wrcount got=%0d exp=4096", wr_count - w0); else pass_cnt++;
    endtask

`ifdef ROM_LOADER_CHKSUM_EN
    task automatic test_chksum();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0F);
        total_cnt++; if ({done_o, err_o} !== 2'b10) $display("FAIL chk_good got=%b exp=10", {done_o, err_o}); else pass_cnt++;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0E);
        total_cnt++; if ({done_o, err_o, cpu_hold_o} !== 3'b010) $display("FAIL chk_bad got=%b exp=010", {done_o, err_o, cpu_hold_o}); else pass_cnt++;
        idle_cycles(1);
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        wr_count  = 0;
        test_reset();
        test_garbage();
        test_basic();
        test_len_errors();
        test_mid_reset();
        test_full_depth();
`ifdef ROM_LOADER_CHKSUM_EN
        test_chksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout time=%0t limit=1000000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
